// File: rtl/ref_scan_ctrl_pkg.sv
// Shared types and constants for the reference-channel scan controller.
// State encoding, table entry layout and channel-mask helpers.
package ref_scan_ctrl_pkg;

  localparam int NCH        = 3;
  localparam int TO_CYC_DEF = 1024;
  localparam int DPOT_W     = 8;
  localparam int DAC_W      = 16;

  localparam logic [DPOT_W-1:0] DPOT_RST = 8'h80;
  localparam logic [DAC_W-1:0]  DAC_RST  = 16'h0000;

  typedef enum logic [3:0] {
    IDLE,
    SEL,
    DPOT_REQ,
    DPOT_WAIT,
    DAC_REQ,
    DAC_WAIT,
    DWELL,
    NEXT,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [DPOT_W-1:0] dpot;
    logic [DAC_W-1:0]  dac;
  } entry_t;

  // lowest set bit of a channel mask (0 if empty)
  function automatic logic [1:0] low_ch(input logic [2:0] m);
    low_ch = 2'd0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i]) low_ch = 2'(i);
  endfunction

  // mask bits strictly above channel c
  function automatic logic [2:0] above(input logic [2:0] m,
                                       input logic [1:0] c);
    above = '0;
    for (int i = 0; i < NCH; i++)
      if (i > int'(c)) above[i] = m[i];
  endfunction

endpackage

// File: rtl/ref_scan_ctrl_scan_timer.sv
// Loadable saturating down-counter shared by dwell and timeout.
// zero is high while the count is exhausted.
module scan_timer
  import ref_scan_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load has priority, otherwise count down to zero and hold
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ref_scan_ctrl.sv
// Scans enabled REF channels: program digipot, then DAC, then dwell
// on the analog mux; optional looping, stop draining, transfer timeout.
module ref_scan_ctrl
  import ref_scan_ctrl_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int TO_CYC  = TO_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_ch,
  input  logic [DPOT_W-1:0]  cfg_dpot,
  input  logic [DAC_W-1:0]   cfg_dac,
  input  logic [2:0]         ch_en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  input  logic               dpot_done,
  input  logic               dac_done,
  output logic               dpot_start,
  output logic [1:0]         dpot_sel,
  output logic [DPOT_W-1:0]  dpot_data,
  output logic               dac_start,
  output logic [DAC_W-1:0]   dac_data,
  output logic [2:0]         mux_ref,
  output logic               busy,
  output logic [1:0]         cur_ch,
  output logic               pass_done,
  output logic               err
);

  localparam int TOW = $clog2(TO_CYC) + 1;
  localparam int TW  = (DWELL_W > TOW) ? DWELL_W : TOW;
  localparam logic [TW-1:0] TO_LD = TW'(TO_CYC - 1);

  state_t       state, nxt;
  logic [1:0]   nxt_ch;
  logic         nxt_pend, pend_dac;
  logic         tload, tzero;
  logic [TW-1:0] tval, dwell_ld;
  logic         set_pd, set_err, clr_err, latch;
  logic [2:0]   up;
  entry_t       tbl [NCH];

  assign dwell_ld = (dwell == '0) ? '0 : TW'(dwell) - TW'(1);
  assign up       = above(ch_en, cur_ch);

  scan_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tload),
    .load_val (tval),
    .zero     (tzero)
  );

  // next-state, timer control and event strobes
  always_comb begin
    nxt      = state;
    nxt_ch   = cur_ch;
    nxt_pend = pend_dac;
    tload    = 1'b0;
    tval     = '0;
    set_pd   = 1'b0;
    set_err  = 1'b0;
    clr_err  = 1'b0;
    latch    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          clr_err = 1'b1;
          if (ch_en != '0) begin
            nxt    = SEL;
            nxt_ch = low_ch(ch_en);
          end else begin
            set_pd = 1'b1;
          end
        end
      end
      SEL: begin
        if (stop) begin
          nxt = IDLE;
        end else begin
          latch = 1'b1;
          nxt   = DPOT_REQ;
        end
      end
      DPOT_REQ: begin
        tload    = 1'b1;
        tval     = TO_LD;
        nxt_pend = 1'b0;
        nxt      = stop ? DRAIN : DPOT_WAIT;
      end
      DPOT_WAIT: begin
        if (dpot_done) begin
          nxt = stop ? IDLE : DAC_REQ;
        end else if (stop) begin
          nxt = DRAIN;
        end else if (tzero) begin
          set_err = 1'b1;
          nxt     = IDLE;
        end
      end
      DAC_REQ: begin
        tload    = 1'b1;
        tval     = TO_LD;
        nxt_pend = 1'b1;
        nxt      = stop ? DRAIN : DAC_WAIT;
      end
      DAC_WAIT: begin
        if (dac_done) begin
          if (stop) begin
            nxt = IDLE;
          end else begin
            nxt   = DWELL;
            tload = 1'b1;
            tval  = dwell_ld;
          end
        end else if (stop) begin
          nxt = DRAIN;
        end else if (tzero) begin
          set_err = 1'b1;
          nxt     = IDLE;
        end
      end
      DWELL: begin
        if (stop)       nxt = IDLE;
        else if (tzero) nxt = NEXT;
      end
      NEXT: begin
        if (stop) begin
          nxt = IDLE;
        end else if (up != '0) begin
          nxt    = SEL;
          nxt_ch = low_ch(up);
        end else begin
          set_pd = 1'b1;
          if (loop && ch_en != '0) begin
            nxt    = SEL;
            nxt_ch = low_ch(ch_en);
          end else begin
            nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        if (pend_dac ? dac_done : dpot_done) begin
          nxt = IDLE;
        end else if (tzero) begin
          set_err = 1'b1;
          nxt     = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // state, channel, flags, latched transfer words and channel table
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_ch    <= '0;
      pend_dac  <= 1'b0;
      pass_done <= 1'b0;
      err       <= 1'b0;
      dpot_data <= '0;
      dac_data  <= '0;
      for (int i = 0; i < NCH; i++)
        tbl[i] <= '{dpot: DPOT_RST, dac: DAC_RST};
    end else begin
      state     <= nxt;
      cur_ch    <= nxt_ch;
      pend_dac  <= nxt_pend;
      pass_done <= set_pd;
      if (set_err)      err <= 1'b1;
      else if (clr_err) err <= 1'b0;
      if (latch) begin
        dpot_data <= tbl[cur_ch].dpot;
        dac_data  <= tbl[cur_ch].dac;
      end
      if (cfg_we && cfg_ch != 2'd3)
        tbl[cfg_ch] <= '{dpot: cfg_dpot, dac: cfg_dac};
    end
  end

  assign busy       = (state != IDLE);
  assign dpot_start = (state == DPOT_REQ);
  assign dac_start  = (state == DAC_REQ);
  assign dpot_sel   = cur_ch;
  assign mux_ref    = (state == DWELL) ? (3'b001 << cur_ch) : 3'b000;

endmodule

// File: tb/tb_ref_scan_ctrl.sv
// Directed bench for ref_scan_ctrl with transfer scoreboard
// and auto-responding serial controller models.
module tb_ref_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, cfg_we, loop, start, stop;
  logic        dpot_done, dac_done;
  logic [1:0]  cfg_ch;
  logic [7:0]  cfg_dpot;
  logic [15:0] cfg_dac;
  logic [2:0]  ch_en;
  logic [15:0] dwell;
  logic        dpot_start, dac_start, busy, pass_done, err;
  logic [1:0]  dpot_sel, cur_ch;
  logic [7:0]  dpot_data;
  logic [15:0] dac_data;
  logic [2:0]  mux_ref;

  ref_scan_ctrl #(.DWELL_W(16), .TO_CYC(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_dpot   (cfg_dpot),
    .cfg_dac    (cfg_dac),
    .ch_en      (ch_en),
    .dwell      (dwell),
    .loop       (loop),
    .start      (start),
    .stop       (stop),
    .dpot_done  (dpot_done),
    .dac_done   (dac_done),
    .dpot_start (dpot_start),
    .dpot_sel   (dpot_sel),
    .dpot_data  (dpot_data),
    .dac_start  (dac_start),
    .dac_data   (dac_data),
    .mux_ref    (mux_ref),
    .busy       (busy),
    .cur_ch     (cur_ch),
    .pass_done  (pass_done),
    .err        (err)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0]  exp_dpot [$];
  logic [15:0] exp_dac  [$];
  int mux_cyc = 0, mux_bad = 0, pd_cnt = 0, n_dpot = 0, n_dac = 0;
  logic [2:0] mux_seen = '0;
  logic hold_dpot = 1'b0, hold_dac = 1'b0;
  int cnt, n0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] d,
                     input logic [15:0] a);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_dpot = d;
    cfg_dac  = a;
    step(1);
    cfg_we   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(tag, 32'(busy), 0);
    step(2);
  endtask

  // scoreboard: every transfer request must match the next expected one
  initial forever begin
    @(negedge clk);
    if (dpot_start) begin
      n_dpot++;
      if (exp_dpot.size() == 0) chk("dpot_extra", 32'(dpot_start), 0);
      else chk("dpot_xfer", 32'({dpot_sel, dpot_data}),
               32'(exp_dpot.pop_front()));
    end
    if (dac_start) begin
      n_dac++;
      if (exp_dac.size() == 0) chk("dac_extra", 32'(dac_start), 0);
      else chk("dac_xfer", 32'(dac_data), 32'(exp_dac.pop_front()));
    end
    if (mux_ref != 3'b000) begin
      mux_cyc++;
      mux_seen = mux_seen | mux_ref;
      if (!$onehot(mux_ref)) mux_bad++;
    end
    if (pass_done) pd_cnt++;
  end

  // digipot serial controller model
  initial begin
    dpot_done = 1'b0;
    forever begin
      @(negedge clk);
      if (dpot_start && !hold_dpot) begin
        repeat (3) @(posedge clk);
        #1 dpot_done = 1'b1;
        @(posedge clk);
        #1 dpot_done = 1'b0;
      end
    end
  end

  // DAC serial controller model
  initial begin
    dac_done = 1'b0;
    forever begin
      @(negedge clk);
      if (dac_start && !hold_dac) begin
        repeat (2) @(posedge clk);
        #1 dac_done = 1'b1;
        @(posedge clk);
        #1 dac_done = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_dpot = '0; cfg_dac = '0;
    ch_en = '0; dwell = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    step(2);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mux", 32'(mux_ref), 0);
    chk("rst_err_pd", 32'({err, pass_done}), 0);
    chk("rst_starts", 32'({dpot_start, dac_start}), 0);
    chk("rst_data", 32'({cur_ch, dpot_data, dac_data}), 0);
    step(1);
    rst = 1'b0;
    step(1);

    // single pass, one channel
    cfg(2'd0, 8'h40, 16'h1234);
    ch_en = 3'b001; dwell = 16'd10; loop = 1'b0;
    exp_dpot.push_back({2'd0, 8'h40});
    exp_dac.push_back(16'h1234);
    mux_cyc = 0; pd_cnt = 0; mux_bad = 0;
    pulse_start();
    @(negedge clk);
    chk("t1_lat_c2", 32'(dpot_start), 0);
    chk("t1_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t1_lat_c3", 32'(dpot_start), 1);
    wait_idle("t1_idle", 200);
    chk("t1_mux_cycles", 32'(mux_cyc), 10);
    chk("t1_pass_done", 32'(pd_cnt), 1);
    chk("t1_left", 32'(exp_dpot.size() + exp_dac.size()), 0);

    // looping over ch0 and ch2, stop in second ch2 dwell
    cfg(2'd2, 8'h22, 16'h2222);
    ch_en = 3'b101; loop = 1'b1; dwell = 16'd4;
    for (int k = 0; k < 2; k++) begin
      exp_dpot.push_back({2'd0, 8'h40});
      exp_dpot.push_back({2'd2, 8'h22});
      exp_dac.push_back(16'h1234);
      exp_dac.push_back(16'h2222);
    end
    n_dpot = 0; pd_cnt = 0; mux_seen = '0; mux_bad = 0;
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (n_dpot >= 4 && mux_ref == 3'b100) break;
    end
    chk("t2_in_dwell", 32'(mux_ref), 4);
    step(1);
    pulse_stop();
    @(negedge clk);
    chk("t2_stop_mux", 32'(mux_ref), 0);
    chk("t2_stop_busy", 32'(busy), 0);
    step(2);
    chk("t2_pass_done", 32'(pd_cnt), 1);
    chk("t2_no_ch1", 32'(mux_seen & 3'b010), 0);
    chk("t2_onehot", 32'(mux_bad), 0);
    chk("t2_left", 32'(exp_dpot.size() + exp_dac.size()), 0);

    // DAC timeout
    hold_dac = 1'b1;
    ch_en = 3'b001; loop = 1'b0; dwell = 16'd2;
    exp_dpot.push_back({2'd0, 8'h40});
    exp_dac.push_back(16'h1234);
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dac_start) break;
    end
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cnt++;
      if (!busy) break;
    end
    chk("t3_to_cycles", 32'(cnt), 1025);
    chk("t3_err", 32'(err), 1);
    chk("t3_mux", 32'(mux_ref), 0);
    step(1);
    hold_dac = 1'b0;

    // empty mask start: immediate pass_done, clears err
    ch_en = 3'b000; pd_cnt = 0; n_dpot = 0;
    pulse_start();
    @(negedge clk);
    chk("t3_err_clr", 32'(err), 0);
    chk("t3_pd_now", 32'(pass_done), 1);
    chk("t3_busy", 32'(busy), 0);
    step(2);
    chk("t3_pd_cnt", 32'(pd_cnt), 1);
    chk("t3_no_xfer", 32'(n_dpot), 0);

    // stop while waiting for the digipot: drain
    hold_dpot = 1'b1;
    ch_en = 3'b001; pd_cnt = 0; n0 = n_dac;
    exp_dpot.push_back({2'd0, 8'h40});
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dpot_start) break;
    end
    step(2);
    pulse_stop();
    @(negedge clk);
    chk("t4_drain_busy", 32'(busy), 1);
    step(3);
    dpot_done = 1'b1;
    step(1);
    dpot_done = 1'b0;
    @(negedge clk);
    chk("t4_idle", 32'(busy), 0);
    step(2);
    chk("t4_no_pd", 32'(pd_cnt), 0);
    chk("t4_no_dac", 32'(n_dac - n0), 0);
    hold_dpot = 1'b0;

    // ch1 from reset table, rewritten during its dwell
    ch_en = 3'b010; loop = 1'b1; dwell = 16'd20;
    exp_dpot.push_back({2'd1, 8'h80});
    exp_dpot.push_back({2'd1, 8'h99});
    exp_dac.push_back(16'h0000);
    exp_dac.push_back(16'h9999);
    n_dpot = 0; pd_cnt = 0;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mux_ref == 3'b010) break;
    end
    chk("t5_dwell1", 32'(mux_ref), 2);
    step(1);
    cfg(2'd1, 8'h99, 16'h9999);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_dpot >= 2 && mux_ref == 3'b010) break;
    end
    chk("t5_dwell2", 32'(mux_ref), 2);
    step(1);
    pulse_stop();
    step(2);
    chk("t5_left", 32'(exp_dpot.size() + exp_dac.size()), 0);
    chk("t5_pass_done", 32'(pd_cnt), 1);

    // reset during DAC wait, stray done afterwards
    hold_dac = 1'b1;
    ch_en = 3'b001; loop = 1'b0; dwell = 16'd3;
    exp_dpot.push_back({2'd0, 8'h40});
    exp_dac.push_back(16'h1234);
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dac_start) break;
    end
    step(3);
    rst = 1'b1;
    step(1);
    @(negedge clk);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_mux", 32'(mux_ref), 0);
    chk("t6_flags", 32'({err, pass_done, dpot_start, dac_start}), 0);
    chk("t6_data", 32'({cur_ch, dpot_data, dac_data}), 0);
    step(1);
    rst = 1'b0;
    hold_dac = 1'b0;
    n0 = n_dac;
    dac_done = 1'b1;
    step(1);
    dac_done = 1'b0;
    step(3);
    chk("t6_stray_busy", 32'(busy), 0);
    chk("t6_stray_dac", 32'(n_dac - n0), 0);

    // reset table restored; dwell 0 behaves as 1
    dwell = 16'd0; mux_cyc = 0;
    exp_dpot.push_back({2'd0, 8'h80});
    exp_dac.push_back(16'h0000);
    pulse_start();
    wait_idle("t7_idle", 200);
    chk("t7_dwell0", 32'(mux_cyc), 1);
    chk("t7_left", 32'(exp_dpot.size() + exp_dac.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
